// File: rtl/image_frame_ctrl.sv
// image_frame_ctrl: frame sequencer that walks a WIDTHxHEIGHT RGB888 pixel RAM
// row by row, one read per pixel, and streams the returned pixels on a
// valid/ready interface with sof/eol/eof markers and a latched op code.
// Latency: start accepted in cycle T -> mem_rd in T+1 -> first out_valid in T+2.
// Backpressure: a 2-entry output FIFO plus one in-flight read; new reads stop
//   while (occupancy + in-flight) reaches 2, so nothing is ever dropped.
// Ports: HCLK/HRESETn clock and async active-low reset; start/op_sel/abort
//   control; mem_rd/mem_addr/mem_rdata pixel RAM (1-cycle read latency);
//   out_* pixel stream; busy (not idle) and done (1-cycle frame-complete pulse).
// Build option: define BOTTOM_UP_EN for bottom-up (BMP-style) RAM layout; the
//   top image row is still streamed first and markers are unchanged.
module image_frame_ctrl #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 4,
  parameter int AW     = 19
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [1:0]    op_sel,
  input  logic          abort,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [23:0]   mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [23:0]   out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [1:0]    out_op,
  output logic          busy,
  output logic          done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_DRAIN} state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [23:0] dat;
  } pix_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [HW-1:0] hb_cnt;
  pix_t          fifo_q [2];
  logic          head;
  logic [1:0]    occ;
  logic          inflight;
  logic [2:0]    fl_mk;     // {sof,eol,eof} of the read currently in flight

  logic          last_col;
  logic          last_row;
  logic          pop;
  logic          push;
  logic          fifo_pop;
  logic [1:0]    occ_nxt;
  logic [AW-1:0] row_base;
  logic [AW-1:0] rd_addr;
  pix_t          rtn_pix;
  pix_t          out_pix;

  assign last_col = (col == CW'(WIDTH - 1));
  assign last_row = (row == RW'(HEIGHT - 1));

  // occ + inflight never exceeds 2, so the 2-bit sum cannot overflow.
  assign mem_rd = (state == ST_ACTIVE) && ((occ + {1'b0, inflight}) < 2'd2);

`ifdef BOTTOM_UP_EN
  assign row_base = AW'(HEIGHT - 1) - AW'(row);
`else
  assign row_base = AW'(row);
`endif
  assign rd_addr  = row_base * AW'(WIDTH) + AW'(col);
  assign mem_addr = mem_rd ? rd_addr : '0;

  // The returning pixel bypasses the FIFO when it is empty, which gives the
  // T+2 first-pixel latency and 1 pixel/cycle with out_ready held high.
  assign rtn_pix = pix_t'({fl_mk, mem_rdata});

  always_comb begin
    out_pix = '0;
    if (occ != 2'd0)
      out_pix = fifo_q[head];
    else if (inflight)
      out_pix = rtn_pix;
  end

  assign out_valid = (occ != 2'd0) || inflight;
  assign out_data  = out_pix.dat;
  assign out_sof   = out_pix.sof;
  assign out_eol   = out_pix.eol;
  assign out_eof   = out_pix.eof;

  assign pop      = out_valid && out_ready;
  assign fifo_pop = pop && (occ != 2'd0);
  // A return consumed straight off the bypass is never stored.
  assign push     = inflight && !(pop && (occ == 2'd0));
  assign occ_nxt  = occ + {1'b0, push} - {1'b0, fifo_pop};

  assign busy = (state != ST_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      hb_cnt    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head      <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      fl_mk     <= 3'b000;
      out_op    <= 2'b00;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Flush everything; the pending RAM return is simply never captured.
        state    <= ST_IDLE;
        head     <= 1'b0;
        occ      <= 2'd0;
        inflight <= 1'b0;
      end else begin
        inflight <= mem_rd;
        if (push)
          fifo_q[head ^ occ[0]] <= rtn_pix;
        if (fifo_pop)
          head <= ~head;
        occ <= occ_nxt;
        if (mem_rd)
          fl_mk <= {(row == '0) && (col == '0), last_col, last_col && last_row};

        case (state)
          ST_IDLE: begin
            if (start) begin
              state  <= ST_ACTIVE;
              out_op <= op_sel;
              row    <= '0;
              col    <= '0;
            end
          end
          ST_ACTIVE: begin
            if (mem_rd) begin
              if (last_col) begin
                col <= '0;
                if (last_row) begin
                  state <= ST_DRAIN;
                end else begin
                  row <= row + RW'(1);
                  if (HBLANK > 0) begin
                    state  <= ST_HBLANK;
                    hb_cnt <= '0;
                  end
                end
              end else begin
                col <= col + CW'(1);
              end
            end
          end
          ST_HBLANK: begin
            if (hb_cnt == HW'(HBLANK - 1))
              state <= ST_ACTIVE;
            else
              hb_cnt <= hb_cnt + HW'(1);
          end
          ST_DRAIN: begin
            // No reads here, so empty-after-this-cycle means fully drained.
            if (occ_nxt == 2'd0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_frame_ctrl.sv
// Bench for image_frame_ctrl: two instances (HBLANK=0 and HBLANK=2) on a
// 4x3 frame share control/ready inputs, each with its own 1-cycle RAM model.
// Observed reads/pops are logged per instance and compared against a frame model.
module tb_image_frame_ctrl;
  localparam int W = 4, H = 3, N = W * H, AWT = 4, MAXL = 64;

  logic clk, rst_n, start, abort, out_ready;
  logic [1:0] op_sel;
  logic rd [2];
  logic [AWT-1:0] adr [2];
  logic [23:0] rdat [2];
  logic vld [2];
  logic [23:0] dat [2];
  logic sof [2], eol [2], eof [2];
  logic [1:0] op [2];
  logic bsy [2], dn [2];
  logic [23:0] mem [16];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [AWT-1:0] rd_adr [2][MAXL];
  int rd_cyc [2][MAXL];
  logic [23:0] pop_dat [2][MAXL];
  logic [2:0] pop_mk [2][MAXL];
  int pop_cyc [2][MAXL];
  int nrd [2], npop [2], ndone [2], done_cyc [2], viol_stab [2], viol_outst [2];
  logic stall_prev [2];
  logic [23:0] stall_dat [2];
  logic [2:0] stall_mk [2];

  image_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .AW(AWT)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .start(start), .op_sel(op_sel), .abort(abort),
    .mem_rd(rd[0]), .mem_addr(adr[0]), .mem_rdata(rdat[0]),
    .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]),
    .out_sof(sof[0]), .out_eol(eol[0]), .out_eof(eof[0]), .out_op(op[0]),
    .busy(bsy[0]), .done(dn[0]));

  image_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .AW(AWT)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .start(start), .op_sel(op_sel), .abort(abort),
    .mem_rd(rd[1]), .mem_addr(adr[1]), .mem_rdata(rdat[1]),
    .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]),
    .out_sof(sof[1]), .out_eol(eol[1]), .out_eof(eof[1]), .out_op(op[1]),
    .busy(bsy[1]), .done(dn[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous pixel RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd[0]) rdat[0] <= mem[adr[0]];
    if (rd[1]) rdat[1] <= mem[adr[1]];
  end

  // Mid-cycle monitor: logs reads, handshakes, done pulses and protocol breaks.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (rd[d]) begin
          if (nrd[d] - npop[d] >= 2) viol_outst[d]++;
          if (nrd[d] < MAXL) begin
            rd_adr[d][nrd[d]] = adr[d];
            rd_cyc[d][nrd[d]] = cyc;
          end
          nrd[d]++;
        end
        if (stall_prev[d] && (!vld[d] || dat[d] !== stall_dat[d] ||
                              {sof[d], eol[d], eof[d]} !== stall_mk[d]))
          viol_stab[d]++;
        if (vld[d] && out_ready) begin
          if (npop[d] < MAXL) begin
            pop_dat[d][npop[d]] = dat[d];
            pop_mk[d][npop[d]]  = {sof[d], eol[d], eof[d]};
            pop_cyc[d][npop[d]] = cyc;
          end
          npop[d]++;
        end
        stall_prev[d] = vld[d] && !out_ready;
        stall_dat[d]  = dat[d];
        stall_mk[d]   = {sof[d], eol[d], eof[d]};
        if (dn[d]) begin
          ndone[d]++;
          done_cyc[d] = cyc;
        end
      end
    end
  end

  // Frame model: k-th streamed pixel is image row k/W, column k%W.
  function automatic int exp_addr(int k);
    int r, c;
    r = k / W;
    c = k % W;
`ifdef BOTTOM_UP_EN
    return (H - 1 - r) * W + c;
`else
    return r * W + c;
`endif
  endfunction

  function automatic logic [2:0] exp_mk(int k);
    return {k == 0, (k % W) == W - 1, k == N - 1};
  endfunction

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      nrd[d] = 0; npop[d] = 0; ndone[d] = 0; done_cyc[d] = -1;
      viol_stab[d] = 0; viol_outst[d] = 0; stall_prev[d] = 1'b0;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
  endtask

  task automatic start_frame(input logic [1:0] o, output int t0);
    start = 1'b1;
    op_sel = o;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    op_sel = 2'($urandom);
  endtask

  // mode 0: ready always high; 1: ready 1,0,0,1 repeating; 2: random ready.
  task automatic run_frame(input int mode, output bit to);
    int i;
    to = 1'b0;
    for (i = 0; i < 300; i++) begin
      if (!bsy[0] && !bsy[1]) break;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((i % 4) == 0) || ((i % 4) == 3);
        default: out_ready = 1'($urandom);
      endcase
      @(posedge clk); #1;
    end
    if (i >= 300) to = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; abort = 0; out_ready = 0; op_sel = 0;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (rd[d] !== 1'b0 || adr[d] !== '0) begin n_fail++;
        $display("FAIL reset_mem dut%0d got rd=%b addr=%0d exp 0/0", d, rd[d], adr[d]); end
      n_chk++; if (vld[d] !== 1'b0) begin n_fail++;
        $display("FAIL reset_valid dut%0d got %b exp 0", d, vld[d]); end
      n_chk++; if (dat[d] !== 24'h0) begin n_fail++;
        $display("FAIL reset_data dut%0d got %h exp 0", d, dat[d]); end
      n_chk++; if ({sof[d], eol[d], eof[d]} !== 3'b000) begin n_fail++;
        $display("FAIL reset_markers dut%0d got %b exp 000", d, {sof[d], eol[d], eof[d]}); end
      n_chk++; if (op[d] !== 2'b00 || bsy[d] !== 1'b0 || dn[d] !== 1'b0) begin n_fail++;
        $display("FAIL reset_ctrl dut%0d got op=%b busy=%b done=%b exp 0", d, op[d], bsy[d], dn[d]); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_stream();
    int t0, hb, er;
    bit to;
    logic [1:0] o;
    clear_logs(); fill_mem(); out_ready = 1'b1;
    o = 2'($urandom);
    start_frame(o, t0);
    run_frame(0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL full_timeout got busy exp idle"); end
    for (int d = 0; d < 2; d++) begin
      hb = (d == 0) ? 0 : 2;
      n_chk++; if (nrd[d] != N || npop[d] != N) begin n_fail++;
        $display("FAIL full_counts dut%0d got rd=%0d pop=%0d exp %0d", d, nrd[d], npop[d], N); end
      n_chk++; if (ndone[d] != 1 || done_cyc[d] != t0 + 1 + (N - 1) + hb * (H - 1) + 2) begin n_fail++;
        $display("FAIL full_done dut%0d got n=%0d at T+%0d exp 1 at T+%0d", d, ndone[d],
                 done_cyc[d] - t0, 1 + (N - 1) + hb * (H - 1) + 2); end
      n_chk++; if (op[d] !== o) begin n_fail++;
        $display("FAIL full_op dut%0d got %b exp %b", d, op[d], o); end
      for (int k = 0; k < N && k < nrd[d] && k < npop[d]; k++) begin
        er = t0 + 1 + k + hb * (k / W);
        n_chk++; if (rd_adr[d][k] !== AWT'(exp_addr(k)) || rd_cyc[d][k] != er) begin n_fail++;
          $display("FAIL full_read dut%0d k=%0d got addr %0d at T+%0d exp %0d at T+%0d", d, k,
                   rd_adr[d][k], rd_cyc[d][k] - t0, exp_addr(k), er - t0); end
        n_chk++; if (pop_dat[d][k] !== mem[exp_addr(k)] || pop_mk[d][k] !== exp_mk(k) ||
                     pop_cyc[d][k] != er + 1) begin n_fail++;
          $display("FAIL full_pixel dut%0d k=%0d got %h/%b at T+%0d exp %h/%b at T+%0d", d, k,
                   pop_dat[d][k], pop_mk[d][k], pop_cyc[d][k] - t0, mem[exp_addr(k)], exp_mk(k), er + 1 - t0); end
      end
    end
  endtask

  task automatic test_ready_pattern(input int mode, input int reps);
    int t0;
    bit to;
    for (int rep = 0; rep < reps; rep++) begin
      clear_logs(); fill_mem();
      start_frame(2'($urandom), t0);
      run_frame(mode, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL bp_timeout mode=%0d got busy exp idle", mode); end
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (npop[d] != N || ndone[d] != 1) begin n_fail++;
          $display("FAIL bp_counts mode=%0d dut%0d got pop=%0d done=%0d exp %0d/1", mode, d, npop[d], ndone[d], N); end
        n_chk++; if (viol_stab[d] != 0 || viol_outst[d] != 0) begin n_fail++;
          $display("FAIL bp_protocol mode=%0d dut%0d got stab=%0d outst=%0d exp 0/0", mode, d,
                   viol_stab[d], viol_outst[d]); end
        for (int k = 0; k < N && k < npop[d]; k++) begin
          n_chk++; if (pop_dat[d][k] !== mem[exp_addr(k)] || pop_mk[d][k] !== exp_mk(k)) begin n_fail++;
            $display("FAIL bp_pixel mode=%0d dut%0d k=%0d got %h/%b exp %h/%b", mode, d, k,
                     pop_dat[d][k], pop_mk[d][k], mem[exp_addr(k)], exp_mk(k)); end
        end
      end
    end
  endtask

  task automatic test_abort();
    int t0, i;
    int snap [2];
    bit to;
    clear_logs(); fill_mem(); out_ready = 1'b1;
    start_frame(2'($urandom), t0);
    for (i = 0; i < 50 && npop[0] < 5; i++) begin @(posedge clk); #1; end
    n_chk++; if (npop[0] < 5) begin n_fail++; $display("FAIL abort_wait got %0d pops exp 5", npop[0]); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (bsy[d] !== 1'b0 || vld[d] !== 1'b0) begin n_fail++;
        $display("FAIL abort_idle dut%0d got busy=%b valid=%b exp 0/0", d, bsy[d], vld[d]); end
      snap[d] = npop[d];
    end
    repeat (20) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (ndone[d] != 0 || npop[d] != snap[d]) begin n_fail++;
        $display("FAIL abort_quiet dut%0d got done=%0d extra_pops=%0d exp 0/0", d, ndone[d], npop[d] - snap[d]); end
    end
    clear_logs(); fill_mem();
    start_frame(2'($urandom), t0);
    run_frame(0, to);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (nrd[d] == 0 || rd_adr[d][0] !== AWT'(exp_addr(0))) begin n_fail++;
        $display("FAIL abort_restart_addr dut%0d got %0d exp %0d", d, rd_adr[d][0], exp_addr(0)); end
      n_chk++; if (npop[d] != N || ndone[d] != 1 || pop_mk[d][0] !== exp_mk(0) ||
                   pop_dat[d][0] !== mem[exp_addr(0)]) begin n_fail++;
        $display("FAIL abort_restart dut%0d got pop=%0d done=%0d mk0=%b exp %0d/1/%b", d,
                 npop[d], ndone[d], pop_mk[d][0], N, exp_mk(0)); end
    end
  endtask

  task automatic test_start_ignored();
    int t0;
    bit to;
    logic [1:0] oa, ob;
    clear_logs(); fill_mem(); out_ready = 1'b1;
    oa = 2'($urandom);
    ob = oa ^ 2'($urandom_range(1, 3));
    start_frame(oa, t0);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; op_sel = ob;
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (op[d] !== oa || bsy[d] !== 1'b1) begin n_fail++;
        $display("FAIL restart_op dut%0d got op=%b busy=%b exp %b/1", d, op[d], bsy[d], oa); end
    end
    run_frame(0, to);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (op[d] !== oa || npop[d] != N || ndone[d] != 1) begin n_fail++;
        $display("FAIL restart_frame dut%0d got op=%b pop=%0d done=%0d exp %b/%0d/1", d, op[d],
                 npop[d], ndone[d], oa, N); end
      for (int k = 0; k < N && k < npop[d]; k++) begin
        n_chk++; if (pop_dat[d][k] !== mem[exp_addr(k)] || pop_mk[d][k] !== exp_mk(k)) begin n_fail++;
          $display("FAIL restart_pixel dut%0d k=%0d got %h/%b exp %h/%b", d, k,
                   pop_dat[d][k], pop_mk[d][k], mem[exp_addr(k)], exp_mk(k)); end
      end
    end
  endtask

  task automatic test_async_reset();
    int t0;
    bit to;
    clear_logs(); fill_mem(); out_ready = 1'b1;
    start_frame(2'b11, t0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (rd[d] !== 1'b0 || vld[d] !== 1'b0 || bsy[d] !== 1'b0 || op[d] !== 2'b00 ||
                   dat[d] !== 24'h0) begin n_fail++;
        $display("FAIL async_reset dut%0d got rd=%b vld=%b busy=%b op=%b data=%h exp all 0", d,
                 rd[d], vld[d], bsy[d], op[d], dat[d]); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs(); fill_mem();
    start_frame(2'($urandom), t0);
    run_frame(0, to);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (npop[d] != N || ndone[d] != 1 || to) begin n_fail++;
        $display("FAIL async_recover dut%0d got pop=%0d done=%0d exp %0d/1", d, npop[d], ndone[d], N); end
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_ready_pattern(1, 1);
    test_ready_pattern(2, 3);
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/image_frame_ctrl.md
Name: image_frame_ctrl

Overview:
Frame sequencer for the image processing datapath. On a start pulse it walks a WIDTHxHEIGHT RGB888 pixel RAM row by row and issues one read per pixel. Returned pixels go out on a valid/ready stream with frame and line markers and a latched operation code. Downstream operators (brightness, grayscale, threshold) then run under flow control instead of free-running counters.

Parameters:
WIDTH, 768, pixels per row
HEIGHT, 512, rows per frame
HBLANK, 4, idle read cycles inserted after each row's last read (0 = none)
AW, 19, pixel address width; must satisfy 2^AW >= WIDTH*HEIGHT

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  single-cycle frame request; honoured only in ST_IDLE
op_sel  in  2  operation code, latched on accepted start
abort  in  1  synchronous frame cancel
mem_rd  out  1  pixel RAM read strobe
mem_addr  out  AW  pixel RAM read address
mem_rdata  in  24  {R,G,B}; valid exactly 1 cycle after mem_rd
out_valid  out  1  stream pixel valid
out_ready  in  1  downstream accept
out_data  out  24  {R,G,B} pixel
out_sof  out  1  first pixel of frame
out_eol  out  1  last pixel of a row
out_eof  out  1  last pixel of frame
out_op  out  2  latched op_sel
busy  out  1  high in any state other than ST_IDLE
done  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset (async, HRESETn=0): state ST_IDLE; row, col, hb_cnt = 0; 2-entry output FIFO empty; in-flight flag clear.
- Reset output values: mem_rd, out_valid, out_sof, out_eol, out_eof, busy, done all 0; mem_addr, out_data, out_op all 0.
- States:
  - ST_IDLE: start=1 -> ST_ACTIVE; latch op_sel; row=col=0.
  - ST_ACTIVE: issues reads.
  - ST_HBLANK: counts HBLANK cycles with no reads, then returns to ST_ACTIVE.
  - ST_DRAIN: issues no reads; waits until the FIFO is empty and nothing is in flight, then asserts done for 1 cycle -> ST_IDLE.
- Read issue rule: mem_rd=1 in ST_ACTIVE iff (FIFO occupancy + in-flight) < 2, counted before this cycle's pop. This allows 1 pixel/cycle sustained throughput when out_ready is held high.
- Address: mem_addr = row*WIDTH + col, top-down. The address is valid together with mem_rd.
- Counter advance on each read:
  - col wraps at WIDTH-1, then row increments.
  - Read at (row, WIDTH-1), not last row: -> ST_HBLANK, or stay in ST_ACTIVE if HBLANK=0.
  - Read at (HEIGHT-1, WIDTH-1): -> ST_DRAIN.
- Markers: computed at issue time and carried through the FIFO with the data.
  - sof = (row==0 && col==0)
  - eol = (col==WIDTH-1)
  - eof = eol && row==HEIGHT-1
- Return path: mem_rdata is captured into the FIFO on the cycle after mem_rd. Capture and pop in the same cycle are allowed.
- Output: head entry is presented on out_data/out_sof/out_eol/out_eof with out_valid=1. A pop occurs when out_valid && out_ready. Outputs stay stable while out_valid=1 and out_ready=0.
- Latency: start accepted at cycle T -> mem_rd at T+1 -> first out_valid at T+2.
- done pulses the cycle after the eof pixel is popped, at the earliest.
- start while busy: ignored; out_op unchanged.
- abort (any non-IDLE state): next cycle ST_IDLE; FIFO flushed; the in-flight return is discarded; out_valid=0; no done. abort in ST_IDLE has no effect. When abort and start arrive in the same cycle in ST_IDLE, start wins.
- Async reset mid-frame: immediately returns to the reset values above.
- Degenerate sizes: WIDTH=1 gives eol on every pixel. WIDTH=HEIGHT=1 gives sof=eol=eof on the single pixel.

Optional Feature:
BOTTOM_UP_EN
- Defined: mem_addr = (HEIGHT-1-row)*WIDTH + col, so BMP-style bottom-up storage streams top row first. Marker generation is unchanged.
- Undefined: top-down addressing as above.

Test Plan:
- WIDTH=4 HEIGHT=3 HBLANK=0, out_ready=1, pulse start -> 12 pixels on consecutive cycles starting at T+2; addresses 0..11; sof on pixel 0; eol on pixels 3,7,11; eof on pixel 11; done at T+14.
- Same sizes with HBLANK=2 -> mem_rd low for exactly 2 cycles after addresses 3 and 7; stream gaps match; total pixels = 12.
- out_ready toggled 1,0,0,1 repeating -> no pixel lost or duplicated; data stable while stalled; FIFO never exceeds 2; mem_rd never issued with occupancy+in-flight=2.
- abort asserted after 5 pixels popped -> busy=0 and out_valid=0 next cycle; no done. A new start then begins at address 0 with sof.
- start pulsed again mid-frame with a different op_sel -> ignored; out_op holds the original code; frame completes normally.
- BOTTOM_UP_EN defined, WIDTH=4 HEIGHT=3 -> address order 8,9,10,11,4..7,0..3; markers identical to the top-down case.
